// File: rtl/ghostbus_host_if.sv
// Bundle of the command stream, response stream and ghostbus signals seen by ghostbus_host.
// The master modport is the host's view; the slave modport is the command source plus bus responders.
interface ghostbus_host_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_wen;
  logic          gb_rstb;
  logic [DW-1:0] gb_rdata;
  logic          busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, gb_rdata,
    output cmd_ready, rsp_valid, rsp_we, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, gb_rdata,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb, busy
  );
endinterface

// File: rtl/ghostbus_host.sv
// Single-outstanding ghostbus initiator: one command in, one bus strobe, one response out.
// Read data is sampled RD cycles after the read strobe; every output is a register.
module ghostbus_host #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int RD = 1
) (
  input logic             gb_clk,
  input logic             gb_rst_n,
  ghostbus_host_if.master bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int         RD_M1    = (RD > 0) ? RD - 1 : 0;
  localparam logic [7:0] CNT_LOAD = RD_M1[7:0];

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       we_r;

  // Transaction FSM; outputs are updated together with the state they belong to.
  always_ff @(posedge gb_clk) begin
    if (!gb_rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 8'd0;
      we_r          <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rdata <= {DW{1'b0}};
      bus.gb_addr   <= {AW{1'b0}};
      bus.gb_wdata  <= {DW{1'b0}};
      bus.gb_wen    <= 1'b0;
      bus.gb_rstb   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.gb_addr   <= bus.cmd_addr;
            // Reads leave the last write data on the bus.
            if (bus.cmd_we) begin
              bus.gb_wdata <= bus.cmd_wdata;
            end
            we_r          <= bus.cmd_we;
            bus.gb_wen    <= bus.cmd_we;
            bus.gb_rstb   <= ~bus.cmd_we;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state_r       <= STROBE;
          end
        end
        STROBE: begin
          bus.gb_wen  <= 1'b0;
          bus.gb_rstb <= 1'b0;
          if (we_r) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_we    <= 1'b1;
            bus.rsp_rdata <= {DW{1'b0}};
            state_r       <= RESP;
          end else if (RD == 0) begin
            // Zero-latency responders answer within the strobe cycle itself.
            bus.rsp_valid <= 1'b1;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= bus.gb_rdata;
            state_r       <= RESP;
          end else begin
            cnt_r   <= CNT_LOAD;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 8'd0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= bus.gb_rdata;
            state_r       <= RESP;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          bus.gb_wen    <= 1'b0;
          bus.gb_rstb   <= 1'b0;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ghostbus_host.sv
// Bench for ghostbus_host: four instances (RD = 1, 3, 0, 5) share one stimulus set selected by sel,
// a register-file responder on the bus, and a command-level reference model of expected responses.
module tb_ghostbus_host;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RDS [4] = '{1, 3, 0, 5};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    sel;
  logic          cmd_valid, cmd_we, rsp_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic [3:0]    cmd_ready_a, rsp_valid_a, rsp_we_a, wen_a, rstb_a, busy_a;
  logic [DW-1:0] rsp_rdata_a [4];
  logic [AW-1:0] gb_addr_a [4];
  logic [DW-1:0] gb_wdata_a [4];

  logic          cur_ready, cur_rsp_valid, cur_rsp_we, cur_wen, cur_rstb, cur_busy;
  logic [DW-1:0] cur_rdata, cur_wdata;
  logic [AW-1:0] cur_addr;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] garbage;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_wdata [4];
  int n_cmp = 0;
  int n_fail = 0;
  int wen_cnt = 0;
  int rstb_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    ghostbus_host_if #(.AW(AW), .DW(DW)) bus ();
    ghostbus_host #(.AW(AW), .DW(DW), .RD(RDS[g])) dut (
      .gb_clk  (clk),
      .gb_rst_n(rst_n),
      .bus     (bus)
    );
    int cd = 0;
    // Responder read timing: data is valid only in the cycle RD after the read strobe.
    always @(posedge clk) begin
      if (bus.gb_rstb) cd <= RDS[g];
      else if (cd > 0) cd <= cd - 1;
    end
    assign bus.gb_rdata  = ((RDS[g] == 0) ? bus.gb_rstb : (cd == 1)) ? mem[bus.gb_addr[3:0]] : garbage;
    assign bus.cmd_valid = cmd_valid && (sel == 2'(g));
    assign bus.cmd_we    = cmd_we;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_wdata = cmd_wdata;
    assign bus.rsp_ready = rsp_ready && (sel == 2'(g));
    assign cmd_ready_a[g] = bus.cmd_ready;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_we_a[g]    = bus.rsp_we;
    assign wen_a[g]       = bus.gb_wen;
    assign rstb_a[g]      = bus.gb_rstb;
    assign busy_a[g]      = bus.busy;
    assign rsp_rdata_a[g] = bus.rsp_rdata;
    assign gb_addr_a[g]   = bus.gb_addr;
    assign gb_wdata_a[g]  = bus.gb_wdata;
  end

  assign cur_ready     = cmd_ready_a[sel];
  assign cur_rsp_valid = rsp_valid_a[sel];
  assign cur_rsp_we    = rsp_we_a[sel];
  assign cur_wen       = wen_a[sel];
  assign cur_rstb      = rstb_a[sel];
  assign cur_busy      = busy_a[sel];
  assign cur_rdata     = rsp_rdata_a[sel];
  assign cur_addr      = gb_addr_a[sel];
  assign cur_wdata     = gb_wdata_a[sel];

  // Responder register file, written on the selected instance's write strobe.
  always @(posedge clk) begin
    garbage <= $urandom;
    if (cur_wen) mem[cur_addr[3:0]] <= cur_wdata;
  end

  // Strobe monitor, sampled mid-cycle across all instances.
  always @(negedge clk) begin
    if (|wen_a) wen_cnt <= wen_cnt + 1;
    if (|rstb_a) rstb_cnt <= rstb_cnt + 1;
    if (|(wen_a & rstb_a)) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents a command from a negedge and returns in the negedge of cycle 1 after acceptance.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    while (!cur_ready && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (cur_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_timeout: cmd_ready=%0b required 1", cur_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready_a, rsp_valid_a, rsp_we_a, wen_a, rstb_a, busy_a} !== {4'hF, 20'h0}) begin
      n_fail++; $display("FAIL reset_flags: got %h required %h",
        {cmd_ready_a, rsp_valid_a, rsp_we_a, wen_a, rstb_a, busy_a}, {4'hF, 20'h0});
    end
    for (int g = 0; g < 4; g++) begin
      n_cmp++;
      if (gb_addr_a[g] !== 24'h0 || gb_wdata_a[g] !== 32'h0 || rsp_rdata_a[g] !== 32'h0) begin
        n_fail++; $display("FAIL reset_data[%0d]: addr=%h wdata=%h rdata=%h required all 0",
          g, gb_addr_a[g], gb_wdata_a[g], rsp_rdata_a[g]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    sel = 2'd0; rsp_ready = 1'b1;
    issue(1'b1, 24'h000010, 32'hDEADBEEF);
    n_cmp++;
    if ({cur_wen, cur_rstb, cur_rsp_valid} !== 3'b100 || cur_addr !== 24'h000010 || cur_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_strobe: wen/rstb/rv=%b addr=%h wdata=%h required 100 000010 deadbeef",
        {cur_wen, cur_rstb, cur_rsp_valid}, cur_addr, cur_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({cur_wen, cur_rsp_valid, cur_rsp_we} !== 3'b011 || cur_rdata !== 32'h0) begin
      n_fail++; $display("FAIL write_resp: wen/rv/we=%b rdata=%h required 011 0",
        {cur_wen, cur_rsp_valid, cur_rsp_we}, cur_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({cur_rsp_valid, cur_ready, cur_busy} !== 3'b010) begin
      n_fail++; $display("FAIL write_done: rv/ready/busy=%b required 010", {cur_rsp_valid, cur_ready, cur_busy});
    end
    ref_mem[0] = 32'hDEADBEEF;
    // Preload the responder for the read tests.
    issue(1'b1, 24'h000005, 32'h00000042); repeat (2) @(negedge clk);
    issue(1'b1, 24'h000004, 32'h12345678); repeat (2) @(negedge clk);
    ref_mem[5] = 32'h00000042; ref_mem[4] = 32'h12345678;
    last_wdata[0] = 32'h12345678;
  endtask

  task automatic test_read(input logic [1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    int n = 1;
    sel = s; rsp_ready = 1'b1;
    issue(1'b0, a, $urandom);
    n_cmp++;
    if ({cur_rstb, cur_wen} !== 2'b10 || cur_addr !== a || cur_wdata !== last_wdata[s]) begin
      n_fail++; $display("FAIL read_strobe[rd=%0d]: rstb/wen=%b addr=%h wdata=%h required 10 %h %h",
        RDS[s], {cur_rstb, cur_wen}, cur_addr, cur_wdata, a, last_wdata[s]);
    end
    while (!cur_rsp_valid && n < 300) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== 2 + RDS[s]) begin
      n_fail++; $display("FAIL read_latency[rd=%0d]: rsp_valid in cycle %0d required %0d", RDS[s], n, 2 + RDS[s]);
    end
    n_cmp++;
    if (cur_rdata !== exp_d || cur_rsp_we !== 1'b0) begin
      n_fail++; $display("FAIL read_data[rd=%0d]: rdata=%h we=%b required %h 0", RDS[s], cur_rdata, cur_rsp_we, exp_d);
    end
    @(negedge clk);
    n_cmp++;
    if ({cur_rsp_valid, cur_ready} !== 2'b01) begin
      n_fail++; $display("FAIL read_done[rd=%0d]: rv/ready=%b required 01", RDS[s], {cur_rsp_valid, cur_ready});
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int w0, r0;
    logic [DW-1:0] d2;
    sel = 2'd0; rsp_ready = 1'b0;
    issue(1'b0, 24'h000005, 32'h0);
    while (!cur_rsp_valid && n < 50) begin @(negedge clk); n++; end
    w0 = wen_cnt; r0 = rstb_cnt;
    d2 = $urandom;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000007; cmd_wdata = d2;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({cur_rsp_valid, cur_ready, cur_wen, cur_rstb} !== 4'b1000 || cur_rdata !== 32'h00000042) begin
        n_fail++; $display("FAIL bp_hold[%0d]: rv/ready/wen/rstb=%b rdata=%h required 1000 00000042",
          i, {cur_rsp_valid, cur_ready, cur_wen, cur_rstb}, cur_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cur_rsp_valid, cur_ready, cur_wen} !== 3'b010 || wen_cnt !== w0 || rstb_cnt !== r0) begin
      n_fail++; $display("FAIL bp_release: rv/ready/wen=%b strobes=%0d/%0d required 010 %0d/%0d",
        {cur_rsp_valid, cur_ready, cur_wen}, wen_cnt, rstb_cnt, w0, r0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (cur_wen !== 1'b1 || cur_addr !== 24'h000007 || cur_wdata !== d2) begin
      n_fail++; $display("FAIL bp_second: wen=%b addr=%h wdata=%h required 1 000007 %h", cur_wen, cur_addr, cur_wdata, d2);
    end
    repeat (2) @(negedge clk);
    ref_mem[7] = d2; last_wdata[0] = d2;
  endtask

  task automatic test_reset_mid_read();
    int w0, r0, seen;
    sel = 2'd3; rsp_ready = 1'b1;
    issue(1'b0, 24'h000005, 32'h0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cur_busy, cur_rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL abort_inflight: busy/rv=%b required 10", {cur_busy, cur_rsp_valid});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cur_rsp_valid, cur_busy, cur_ready, cur_rstb} !== 4'b0010 || cur_addr !== 24'h0) begin
      n_fail++; $display("FAIL abort_reset: rv/busy/ready/rstb=%b addr=%h required 0010 0",
        {cur_rsp_valid, cur_busy, cur_ready, cur_rstb}, cur_addr);
    end
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) last_wdata[g] = 32'h0;
    w0 = wen_cnt; r0 = rstb_cnt; seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (|rsp_valid_a) seen++;
    end
    n_cmp++;
    if (seen !== 0 || wen_cnt !== w0 || rstb_cnt !== r0) begin
      n_fail++; $display("FAIL abort_quiet: responses=%0d strobes=%0d/%0d required 0 %0d/%0d",
        seen, wen_cnt, rstb_cnt, w0, r0);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW:0] exp_q [$];
    int n_wr = 0, n_rd = 0, got = 0;
    int w0, r0;
    sel = 2'd0; rsp_ready = 1'b0;
    w0 = wen_cnt; r0 = rstb_cnt;
    fork
      begin : driver
        for (int i = 0; i < 100; i++) begin
          logic we;
          logic [3:0] a;
          logic [DW-1:0] d;
          int n = 0;
          we = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
          a  = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
          d  = $urandom;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          cmd_valid = 1'b1; cmd_we = we; cmd_addr = {20'h0, a}; cmd_wdata = d;
          while (!cur_ready && n < 500) begin @(negedge clk); n++; end
          if (!cur_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_accept_timeout: cmd %0d never accepted", i);
            cmd_valid = 1'b0;
            break;
          end
          if (we) begin
            ref_mem[a] = d; exp_q.push_back({1'b1, 32'h0}); n_wr++;
          end else begin
            exp_q.push_back({1'b0, ref_mem[a]}); n_rd++;
          end
          @(negedge clk);
          cmd_valid = 1'b0;
        end
      end
      begin : collector
        int n = 0;
        logic [DW:0] e;
        while (got < 100 && n < 5000) begin
          @(negedge clk); n++;
          rsp_ready = 1'($urandom_range(0, 1));
          if (cur_rsp_valid && rsp_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 32'hBAD0BAD0};
            n_cmp++;
            if ({cur_rsp_we, cur_rdata} !== e) begin
              n_fail++; $display("FAIL stream_rsp[%0d]: we=%b rdata=%h required we=%b rdata=%h",
                got, cur_rsp_we, cur_rdata, e[DW], e[DW-1:0]);
            end
            got++;
          end
        end
      end
    join
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (got !== 100 || wen_cnt - w0 !== n_wr || rstb_cnt - r0 !== n_rd || n_wr + n_rd !== 100) begin
      n_fail++; $display("FAIL stream_counts: rsp=%0d wen=%0d rstb=%0d required 100 %0d %0d (issued %0d)",
        got, wen_cnt - w0, rstb_cnt - r0, n_wr, n_rd, n_wr + n_rd);
    end
    n_cmp++;
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL strobe_overlap: gb_wen and gb_rstb together in %0d cycles required 0", both_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'd0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    for (int g = 0; g < 4; g++) last_wdata[g] = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read(2'd0, 24'h000005, 32'h00000042);
    test_read(2'd1, 24'h000005, 32'h00000042);
    test_read(2'd2, 24'h000004, 32'h12345678);
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ghostbus_host.md
# ghostbus_host

Single-outstanding initiator that drives a ghostbus (gb_addr, gb_wdata, gb_wen, gb_rstb, gb_rdata) from a valid/ready command stream and returns one response per command. It is the master end of the bus that decoded modules respond on. Upstream it serves as the landing point for a host link such as a UART, packet or JTAG bridge; downstream it connects directly to the ghostbus ports of a top-level module.

## Interface
Parameters:
- AW, 24, ghostbus address width
- DW, 32, ghostbus data width
- RD, 1, read latency in cycles from the gb_rstb cycle to the gb_rdata sample; legal range 0..255

Ports:
- gb_clk  in  1  bus clock; the only clock
- gb_rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both are high at the edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  target address
- cmd_wdata  in  DW  write data; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both are high at the edge
- rsp_we  out  1  echo of cmd_we for this response
- rsp_rdata  out  DW  read data; 0 for writes
- gb_addr  out  AW  bus address
- gb_wdata  out  DW  bus write data
- gb_wen  out  1  one-cycle write strobe
- gb_rstb  out  1  one-cycle read strobe
- gb_rdata  in  DW  bus read data from the responders
- busy  out  1  high whenever state != IDLE

## Operation
- States are IDLE, STROBE, WAIT and RESP. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_addr into gb_addr and cmd_wdata into gb_wdata (write only; reads leave gb_wdata unchanged), latch cmd_we, then go to STROBE.
- STROBE (exactly 1 cycle):
  - A write drives gb_wen = 1, then goes to RESP.
  - A read drives gb_rstb = 1. If RD = 0, it samples gb_rdata at the end of this cycle and goes to RESP. Otherwise it loads cnt = RD-1 and goes to WAIT.
- WAIT:
  - If cnt = 0, sample gb_rdata into rsp_rdata and go to RESP.
  - Otherwise decrement cnt. cnt is 8 bits.
- RESP:
  - rsp_valid = 1, with rsp_we and rsp_rdata held stable.
  - When rsp_ready is high, go to IDLE. rsp_valid drops on that edge.
  - A write response carries rsp_rdata = 0.
- gb_wen and gb_rstb are never high together. Each is high for exactly one cycle per command.
- gb_addr and gb_wdata stay stable from the STROBE cycle until the next accepted command. They do not return to 0 between transactions.
- cmd_ready is 0 in STROBE, WAIT and RESP. Only one transaction is outstanding at a time.
- Commands presented while not ready are held off with no side effects.

## Timing
- Reset values: cmd_ready = 1 (state IDLE); rsp_valid, rsp_we, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb, busy and cnt all 0.
- A reset asserted mid-transaction aborts it: there is no response and no further strobes. State returns to IDLE on the next edge.
- Take cycle 0 as the accept edge. For a write, gb_wen is high in cycle 1 and rsp_valid is high from cycle 2. Minimum write turnaround is 3 cycles per command.
- For a read, gb_rstb is high in cycle 1. gb_rdata is sampled at the end of cycle 1+RD. rsp_valid is high from cycle 2+RD.
- cmd_valid may be high in the same cycle rsp_ready completes a response. It is not accepted until the cycle after, when the block is back in IDLE.
- rsp_valid stays high with stable data for any number of rsp_ready-low cycles.

## Test plan
- **Write, RD=1:** cmd we=1, addr=0x000010, wdata=0xDEADBEEF, rsp_ready=1. Required: gb_wen high for one cycle with gb_addr=0x000010 and gb_wdata=0xDEADBEEF; rsp_valid one cycle later with rsp_we=1 and rsp_rdata=0.
- **Read, RD=1 and RD=3:** model responder returns 0x00000042 exactly RD cycles after gb_rstb and garbage otherwise. Required: rsp_rdata=0x00000042, and rsp_valid asserts 2+RD cycles after accept.
- **Read, RD=0:** responder drives gb_rdata combinationally, 0x12345678 for addr 0x000004. Required: response 0x12345678 with rsp_valid 2 cycles after accept.
- **Response backpressure:** rsp_ready held low for 10 cycles after rsp_valid, with a second command pending. Required: rsp_valid and rsp_rdata stable throughout, cmd_ready=0, no extra strobes, second command accepted only after the handshake.
- **Reset mid-read:** RD=5, assert gb_rst_n=0 during WAIT. Required: next edge gives rsp_valid=0, busy=0, cmd_ready=1, gb_addr=0, and no response ever appears for the aborted read.
- **Back-to-back stream:** 100 random read/write commands against a register-file model, with random cmd_valid and rsp_ready gaps. Required: readback matches the model, exactly one strobe and one response per command, and gb_wen and gb_rstb never high together.
